// File: rtl/alu_sequencer.sv
// Command front-end for a free-running registered ALU: issues one captured op per
// command, holds the accumulator between commands and guards divide-by-zero.
module alu_sequencer #(
   parameter logic [7:0] DIV0_VALUE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   output logic       busy
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 4;

   localparam logic [2:0] S_CLEAR   = 3'd0;
   localparam logic [2:0] S_IDLE    = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
   localparam logic [OP_W-1:0] OP_HOLD  = 4'd4;
   localparam logic [OP_W-1:0] OP_CLEAR = 4'd9;

   logic [2:0]        state, state_nxt;
   logic [OP_W-1:0]   op_q, op_nxt;
   logic [DATA_W-1:0] a_q, a_nxt;
   logic [DATA_W-1:0] b_q, b_nxt;
   logic              div0_q, div0_nxt;

   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              rsp_err_nxt;
   logic [DATA_W-1:0] alu_a_nxt, alu_b_nxt;
   logic [OP_W-1:0]   alu_sel_nxt;
   logic              cmd_ready_nxt, busy_nxt;

   // State, captured command and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_CLEAR;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         div0_q    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= OP_CLEAR;
         cmd_ready <= 1'b0;
         busy      <= 1'b1;
      end else begin
         state     <= state_nxt;
         op_q      <= op_nxt;
         a_q       <= a_nxt;
         b_q       <= b_nxt;
         div0_q    <= div0_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
         alu_a     <= alu_a_nxt;
         alu_b     <= alu_b_nxt;
         alu_sel   <= alu_sel_nxt;
         cmd_ready <= cmd_ready_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next state, command capture and response update
   always_comb begin
      state_nxt     = state;
      op_nxt        = op_q;
      a_nxt         = a_q;
      b_nxt         = b_q;
      div0_nxt      = div0_q;
      rsp_valid_nxt = rsp_valid;
      rsp_data_nxt  = rsp_data;
      rsp_err_nxt   = rsp_err;

      case (state)
         S_CLEAR: state_nxt = S_IDLE;
         S_IDLE: begin
            if (cmd_valid) begin
               op_nxt    = cmd_op;
               a_nxt     = cmd_a;
               b_nxt     = cmd_b;
               div0_nxt  = (cmd_op == OP_DIV) && (cmd_b == '0);
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            rsp_data_nxt  = div0_q ? DIV0_VALUE : alu_out;
            rsp_err_nxt   = div0_q;
            rsp_valid_nxt = 1'b1;
            state_nxt     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = S_IDLE;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // ALU drive for the coming cycle: the captured op only while in ISSUE, hold otherwise
   always_comb begin
      alu_sel_nxt   = OP_HOLD;
      alu_a_nxt     = '0;
      alu_b_nxt     = '0;
      cmd_ready_nxt = (state_nxt == S_IDLE);
      busy_nxt      = (state_nxt != S_IDLE);

      if (state_nxt == S_CLEAR) begin
         alu_sel_nxt = OP_CLEAR;
      end else if (state_nxt == S_ISSUE && !div0_nxt) begin
         alu_sel_nxt = op_nxt;
         alu_a_nxt   = a_nxt;
         alu_b_nxt   = b_nxt;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural registered ALU, directed vector table,
// hand-written multi-cycle sequences and a randomized run against a transaction model.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_out = 8'h00;
   logic       busy;

   int n_chk = 0;
   int n_pass = 0;
   int div0_hits = 0;
   logic [7:0] acc_m;

   always #5 clk = ~clk;

   alu_sequencer #(.DIV0_VALUE(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .busy(busy)
   );

   // ALU behaviour: result is written to the output register, which is also the accumulator
   function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] acc);
      logic [7:0] r;
      case (sel)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = a * b;
         4'h3: r = (b == 8'd0) ? 8'h00 : a / b;
         4'h4: r = acc + a;
         4'h5: r = acc * a;
         4'h6: r = acc + a * b;
         4'h7: r = {a[6:0], a[7]};
         4'h8: r = {a[0], a[7:1]};
         4'h9: r = a & b;
         4'hA: r = a | b;
         4'hB: r = a ^ b;
         4'hC: r = ~(a & b);
         4'hD: r = (a == b) ? 8'hFF : 8'h00;
         4'hE: r = (a > b) ? 8'hFF : 8'h00;
         4'hF: r = (a < b) ? 8'hFF : 8'h00;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   always @(posedge clk) alu_out <= alu_f(alu_sel, alu_a, alu_b, alu_out);

   always @(negedge clk) if (!rst && alu_sel == 4'd3 && alu_b == 8'd0) div0_hits++;

   // Transaction-level expectation: div-by-zero substitutes and leaves the accumulator alone
   function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      logic [7:0] r;
      if (op == 4'd3 && b == 8'd0) return {1'b1, 8'hFF};
      r = alu_f(op, a, b, acc_m);
      acc_m = r;
      return {1'b0, r};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_to(input string name);
      n_chk++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      acc_m = 8'h00;
      @(negedge clk);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
      if (!rsp_valid) fail_to("rsp_valid_wait");
   endtask

   task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      n = 0;
      while (!cmd_ready && n < 64) begin @(negedge clk); n++; end
      if (!cmd_ready) fail_to("cmd_ready_wait");
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int stall, output logic [7:0] d, output logic e,
                       output int lat, output logic busy_after);
      offer(op, a, b);
      wait_rsp(lat);
      d = rsp_data;
      e = rsp_err;
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      busy_after = busy;
   endtask

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
      logic       err;
   } vec_t;

   vec_t vt[15];

   initial begin
      logic [7:0] d, d0;
      logic       e, bz;
      logic [8:0] m;
      int         lat, bad;

      vt[0]  = '{4'h0, 8'd3,   8'd4,   8'd7,   1'b0};
      vt[1]  = '{4'h1, 8'd5,   8'd7,   8'hFE,  1'b0};
      vt[2]  = '{4'h2, 8'd16,  8'd17,  8'h10,  1'b0};
      vt[3]  = '{4'h3, 8'd200, 8'd0,   8'hFF,  1'b1};
      vt[4]  = '{4'h3, 8'd200, 8'd7,   8'd28,  1'b0};
      vt[5]  = '{4'h7, 8'h81,  8'h00,  8'h03,  1'b0};
      vt[6]  = '{4'h8, 8'h01,  8'h00,  8'h80,  1'b0};
      vt[7]  = '{4'h9, 8'hF0,  8'h3C,  8'h30,  1'b0};
      vt[8]  = '{4'hA, 8'hF0,  8'h0F,  8'hFF,  1'b0};
      vt[9]  = '{4'hB, 8'hFF,  8'h0F,  8'hF0,  1'b0};
      vt[10] = '{4'hC, 8'hFF,  8'h0F,  8'hF0,  1'b0};
      vt[11] = '{4'hD, 8'd7,   8'd7,   8'hFF,  1'b0};
      vt[12] = '{4'hE, 8'd5,   8'd3,   8'hFF,  1'b0};
      vt[13] = '{4'hF, 8'd5,   8'd3,   8'h00,  1'b0};
      vt[14] = '{4'hD, 8'd7,   8'd8,   8'h00,  1'b0};

      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;

      // Reset values while rst is held
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_busy",      32'(busy),      32'd1);
      chk("rst_alu_sel",   32'(alu_sel),   32'h9);
      chk("rst_alu_ab",    32'({alu_a, alu_b}), 32'd0);
      rst = 1'b0;
      acc_m = 8'h00;
      @(negedge clk);
      chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
      chk("busy_after_rst",      32'(busy),      32'd0);

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         send(vt[i].op, vt[i].a, vt[i].b, 0, d, e, lat, bz);
         m = model(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].exp));
         chk($sformatf("vec%0d_err", i),  32'(e), 32'(vt[i].err));
         chk($sformatf("vec%0d_lat", i),  32'(lat), 32'd2);
         chk($sformatf("vec%0d_busy", i), 32'(bz), 32'd0);
      end
      chk("div0_never_issued", 32'(div0_hits), 32'd0);

      // Accumulator survives a long idle gap
      send(4'h0, 8'd2, 8'd3, 0, d, e, lat, bz);
      m = model(4'h0, 8'd2, 8'd3);
      chk("chain_add", 32'(d), 32'd5);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (alu_sel !== 4'h4 || alu_a !== 8'h00 || alu_b !== 8'h00) bad++;
      end
      chk("idle_hold_op", 32'(bad), 32'd0);
      send(4'h6, 8'd4, 8'd6, 0, d, e, lat, bz);
      m = model(4'h6, 8'd4, 8'd6);
      chk("chain_mac", 32'(d), 32'd29);
      send(4'h4, 8'd1, 8'd0, 0, d, e, lat, bz);
      m = model(4'h4, 8'd1, 8'd0);
      chk("chain_adda", 32'(d), 32'd30);

      // Response stall with a command waiting behind it
      offer(4'h2, 8'd16, 8'd17);
      m = model(4'h2, 8'd16, 8'd17);
      wait_rsp(lat);
      d0 = rsp_data;
      chk("stall_mul_data", 32'(d0), 32'h10);
      cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'd1; cmd_b = 8'd1;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("stall_stable", 32'(bad), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("stall_rsp_dropped", 32'(rsp_valid), 32'd0);
      chk("stall_ready_back",  32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("stall_cmd_taken", 32'(cmd_ready), 32'd0);
      m = model(4'h0, 8'd1, 8'd1);
      wait_rsp(lat);
      chk("stall_next_data", 32'(rsp_data), 32'd2);
      chk("stall_next_data_keep", 32'(rsp_data), 32'(m[7:0]));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset while a response is pending
      send(4'h0, 8'd3, 8'd0, 0, d, e, lat, bz);
      offer(4'h5, 8'd5, 8'd0);
      wait_rsp(lat);
      chk("mula_data", 32'(rsp_data), 32'd15);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_alu_sel",   32'(alu_sel),   32'h9);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      acc_m = 8'h00;
      send(4'h4, 8'd9, 8'd0, 0, d, e, lat, bz);
      m = model(4'h4, 8'd9, 8'd0);
      chk("midrst_adda", 32'(d), 32'd9);

      // Randomized commands against the transaction model
      do_reset();
      for (int i = 0; i < 150; i++) begin
         logic [3:0] op;
         logic [7:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         send(op, a, b, $urandom_range(0, 2), d, e, lat, bz);
         m = model(op, a, b);
         chk($sformatf("rnd%0d_op%0h_data", i, op), 32'(d), 32'(m[7:0]));
         chk($sformatf("rnd%0d_op%0h_err", i, op),  32'(e), 32'(m[8]));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk("div0_never_issued_final", 32'(div0_hits), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
